// File: rtl/noc_vc_input_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_vc_input_buffer_if
// Description : Upstream, downstream and status bundle of the per-VC input
//               buffer. The buffer uses the slave view. The driving
//               environment uses the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface noc_vc_input_buffer_if #(
  parameter int FLIT_WIDTH = 64,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                         i_clear;
  logic [CHANNELS-1:0]          i_valid;
  logic [CHANNELS-1:0]          o_ready;
  logic [FLIT_WIDTH-1:0]        i_flit;
  logic [CHANNELS-1:0]          o_credit_return;
  logic [CHANNELS-1:0]          o_valid;
  logic [CHANNELS-1:0]          i_ready;
  logic [CHANNELS*FLIT_WIDTH-1:0] o_flit;
  logic [CHANNELS*CW-1:0]       o_count;
  logic [CHANNELS-1:0]          o_empty;
  logic [CHANNELS-1:0]          o_full;
  logic [CHANNELS-1:0]          o_almost_full;
  logic [1:0]                   o_error;

  modport master (
    output i_clear, i_valid, i_flit, i_ready,
    input  o_ready, o_credit_return, o_valid, o_flit, o_count,
           o_empty, o_full, o_almost_full, o_error
  );

  modport slave (
    input  i_clear, i_valid, i_flit, i_ready,
    output o_ready, o_credit_return, o_valid, o_flit, o_count,
           o_empty, o_full, o_almost_full, o_error
  );
endinterface
`default_nettype wire

// File: rtl/noc_vc_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : noc_vc_input_buffer
// Description : Per-virtual-channel input buffer for a router input port.
//               Each channel has one FIFO. The FIFO reports its occupancy and
//               has an almost-full flag. Upstream flow control is valid/ready
//               or credit based. Overflow and multi-hot pushes are recorded in
//               sticky protocol-error bits.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_vc_input_buffer #(
  parameter int FLIT_WIDTH  = 64,
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = 6,
  parameter int CREDIT_MODE = 0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  noc_vc_input_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL = CW'(AFULL_LEVEL);
  localparam logic          C_CREDIT = (CREDIT_MODE != 0);

  logic                w_multi_hot;
  logic [CHANNELS-1:0] w_full;
  logic [CHANNELS-1:0] w_pop;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_overflow;
  logic [CHANNELS-1:0] r_credit;
  logic [1:0]          r_error;

  // A push is legal only when at most one channel is addressed this cycle
  assign w_multi_hot = (bus.i_valid & (bus.i_valid - CHANNELS'(1))) != '0;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]         r_wr_ptr;
      logic [PW-1:0]         r_rd_ptr;
      logic [CW-1:0]         r_count;

      assign w_full[c] = (r_count == C_DEPTH);
      assign w_pop[c]  = (r_count != '0) && bus.i_ready[c];

      if (CREDIT_MODE != 0) begin : g_credit
        // Upstream counts credits. A push into a full channel is accepted
        // only when a pop in the same cycle frees a slot. Otherwise the
        // push is a protocol violation.
        assign w_push[c]     = bus.i_valid[c] && !w_multi_hot && (!w_full[c] || w_pop[c]);
        assign w_overflow[c] = bus.i_valid[c] && !w_multi_hot && w_full[c] && !w_pop[c];
        assign bus.o_ready[c] = 1'b1;
      end else begin : g_valid_ready
        // Ready depends only on the registered state. A same-cycle pop does
        // not let a push into a full channel.
        assign w_push[c]     = bus.i_valid[c] && !w_multi_hot && !w_full[c];
        assign w_overflow[c] = 1'b0;
        assign bus.o_ready[c] = !w_full[c];
      end

      // Storage write. A flush in the same cycle drops the flit.
      always_ff @(posedge clk) begin
        if (w_push[c] && !bus.i_clear) begin
          r_mem[r_wr_ptr] <= bus.i_flit;
        end
      end

      // Pointers and occupancy. Clear overrides push and pop.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else if (bus.i_clear) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push[c]) r_wr_ptr <= r_wr_ptr + PW'(1);
          if (w_pop[c])  r_rd_ptr <= r_rd_ptr + PW'(1);
          case ({w_push[c], w_pop[c]})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
        end
      end

      assign bus.o_valid[c]                          = (r_count != '0);
      assign bus.o_empty[c]                          = (r_count == '0);
      assign bus.o_full[c]                           = w_full[c];
      assign bus.o_almost_full[c]                    = (r_count >= C_AFULL);
      assign bus.o_count[c*CW +: CW]                 = r_count;
      assign bus.o_flit[c*FLIT_WIDTH +: FLIT_WIDTH]  = r_mem[r_rd_ptr];
    end
  endgenerate

  // One credit pulse per popped flit, a cycle late. Flushed flits return none.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= '0;
    end else if (bus.i_clear) begin
      r_credit <= '0;
    end else begin
      r_credit <= w_pop & {CHANNELS{C_CREDIT}};
    end
  end

  // Sticky protocol errors: [1] multi-hot push, [0] overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error <= 2'b00;
    end else if (bus.i_clear) begin
      r_error <= 2'b00;
    end else begin
      r_error <= r_error | {w_multi_hot, |w_overflow};
    end
  end

  assign bus.o_credit_return = r_credit;
  assign bus.o_error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_noc_vc_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_vc_input_buffer
// Description : Self-checking bench with a flit scoreboard. Instance A uses
//               valid/ready flow control. Instance B uses credit flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_vc_input_buffer;
  localparam int FW    = 64;
  localparam int CH    = 2;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_vc_input_buffer_if #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DEPTH)) bus_a ();
  noc_vc_input_buffer_if #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DEPTH)) bus_b ();

  noc_vc_input_buffer #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DEPTH),
                        .AFULL_LEVEL(AFL), .CREDIT_MODE(0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  noc_vc_input_buffer #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DEPTH),
                        .AFULL_LEVEL(AFL), .CREDIT_MODE(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct {
    int          d;
    int          c;
    logic [FW-1:0] f;
  } sb_t;

  sb_t        sb[$];
  logic [1:0] exp_err [2];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         seq    = 0;

  // Output accessors for instance d
  function automatic logic [CW-1:0] cnt(input int d, input int c);
    return (d != 0) ? bus_b.o_count[c*CW +: CW] : bus_a.o_count[c*CW +: CW];
  endfunction
  function automatic logic [FW-1:0] flit(input int d, input int c);
    return (d != 0) ? bus_b.o_flit[c*FW +: FW] : bus_a.o_flit[c*FW +: FW];
  endfunction
  function automatic logic [1:0] err(input int d);
    return (d != 0) ? bus_b.o_error : bus_a.o_error;
  endfunction
  function automatic logic [1:0] cred(input int d);
    return (d != 0) ? bus_b.o_credit_return : bus_a.o_credit_return;
  endfunction

  function automatic int sb_size(input int d, input int c);
    int n = 0;
    foreach (sb[i]) if (sb[i].d == d && sb[i].c == c) n++;
    return n;
  endfunction

  function automatic logic [FW-1:0] next_flit();
    seq++;
    return {32'hF1A7_0000 | 32'(seq), 32'(seq) * 32'h9E37_79B9};
  endfunction

  // One clock cycle on instance d. Expected flits go into the scoreboard on
  // accepted pushes. The head flit is compared on each pop. Credit and error
  // are checked after the edge.
  task automatic cyc(input int d, input logic clr, input logic [1:0] v,
                     input logic [FW-1:0] f, input logic [1:0] r);
    logic [1:0] pops;
    logic [1:0] exp_cred;
    logic       ovf;
    logic       multi;
    int         sz [2];
    pops  = 2'b00;
    ovf   = 1'b0;
    multi = (v == 2'b11);
    for (int c = 0; c < CH; c++) sz[c] = sb_size(d, c);
    if (clr) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == d) sb.delete(i);
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (r[c] && sz[c] != 0) begin
          pops[c] = 1'b1;
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].d == d && sb[i].c == c) begin
              n_chk++;
              if (flit(d, c) !== sb[i].f)
                $display("FAIL pop_flit d%0d ch%0d: got %h expected %h", d, c, flit(d, c), sb[i].f);
              else n_pass++;
              sb.delete(i);
              break;
            end
          end
        end
      end
      if (!multi) begin
        for (int c = 0; c < CH; c++) begin
          if (v[c]) begin
            if (sz[c] < DEPTH || (d == 1 && pops[c])) sb.push_back('{d, c, f});
            else if (d == 1) ovf = 1'b1;
          end
        end
      end
    end
    if (d == 0) begin
      bus_a.i_clear = clr; bus_a.i_valid = v; bus_a.i_flit = f; bus_a.i_ready = r;
      bus_b.i_clear = 1'b0; bus_b.i_valid = '0; bus_b.i_flit = '0; bus_b.i_ready = '0;
    end else begin
      bus_b.i_clear = clr; bus_b.i_valid = v; bus_b.i_flit = f; bus_b.i_ready = r;
      bus_a.i_clear = 1'b0; bus_a.i_valid = '0; bus_a.i_flit = '0; bus_a.i_ready = '0;
    end
    @(posedge clk);
    #1;
    exp_err[d] = clr ? 2'b00 : (exp_err[d] | {multi, ovf});
    exp_cred   = (d == 1 && !clr) ? pops : 2'b00;
    n_chk++;
    if (err(d) !== exp_err[d]) $display("FAIL error d%0d: got %b expected %b", d, err(d), exp_err[d]);
    else n_pass++;
    n_chk++;
    if (cred(d) !== exp_cred) $display("FAIL credit d%0d: got %b expected %b", d, cred(d), exp_cred);
    else n_pass++;
  endtask

  task automatic idle(input int d);
    cyc(d, 1'b0, 2'b00, '0, 2'b00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.i_clear = 1'b0; bus_a.i_valid = '0; bus_a.i_flit = '0; bus_a.i_ready = '0;
    bus_b.i_clear = 1'b0; bus_b.i_valid = '0; bus_b.i_flit = '0; bus_b.i_ready = '0;
    exp_err[0] = 2'b00;
    exp_err[1] = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (cnt(d, 0) !== '0 || cnt(d, 1) !== '0) $display("FAIL reset_count d%0d: got %0d/%0d expected 0/0", d, cnt(d, 0), cnt(d, 1));
      else n_pass++;
      n_chk++;
      if (err(d) !== 2'b00 || cred(d) !== 2'b00) $display("FAIL reset_err_cred d%0d: got %b/%b expected 00/00", d, err(d), cred(d));
      else n_pass++;
    end
    n_chk++;
    if (bus_a.o_empty !== 2'b11 || bus_a.o_valid !== 2'b00 || bus_a.o_full !== 2'b00 || bus_a.o_almost_full !== 2'b00)
      $display("FAIL reset_flags: got empty=%b valid=%b full=%b af=%b expected 11/00/00/00",
               bus_a.o_empty, bus_a.o_valid, bus_a.o_full, bus_a.o_almost_full);
    else n_pass++;
    n_chk++;
    if (bus_a.o_ready !== 2'b11 || bus_b.o_ready !== 2'b11)
      $display("FAIL reset_ready: got %b/%b expected 11/11", bus_a.o_ready, bus_b.o_ready);
    else n_pass++;
  endtask

  task automatic test_fifo_order();
    cyc(0, 1'b0, 2'b01, next_flit(), 2'b00);
    n_chk++;
    if (bus_a.o_valid[0] !== 1'b1) $display("FAIL first_valid: got %b expected 1", bus_a.o_valid[0]);
    else n_pass++;
    cyc(0, 1'b0, 2'b01, next_flit(), 2'b00);
    cyc(0, 1'b0, 2'b01, next_flit(), 2'b00);
    n_chk++;
    if (cnt(0, 0) !== CW'(3)) $display("FAIL count3: got %0d expected 3", cnt(0, 0));
    else n_pass++;
    repeat (3) cyc(0, 1'b0, 2'b00, '0, 2'b01);
    n_chk++;
    if (bus_a.o_empty[0] !== 1'b1) $display("FAIL drained_empty: got %b expected 1", bus_a.o_empty[0]);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(0, 1'b0, 2'b10, next_flit(), 2'b00);
      n_chk++;
      if (bus_a.o_almost_full[1] !== (i >= AFL) || cnt(0, 1) !== CW'(i))
        $display("FAIL fill ch1 step %0d: got af=%b count=%0d expected af=%b count=%0d",
                 i, bus_a.o_almost_full[1], cnt(0, 1), (i >= AFL), i);
      else n_pass++;
    end
    n_chk++;
    if (bus_a.o_full[1] !== 1'b1 || bus_a.o_ready[1] !== 1'b0 || bus_a.o_ready[0] !== 1'b1)
      $display("FAIL full_ch1: got full=%b ready=%b expected full=1 ready=01", bus_a.o_full[1], bus_a.o_ready);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    repeat (DEPTH) cyc(0, 1'b0, 2'b01, next_flit(), 2'b00);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1'b0, 2'b01, next_flit(), (i % 2 == 0) ? 2'b01 : 2'b00);
      n_chk++;
      if (cnt(0, 0) !== CW'(sb_size(0, 0)) || bus_a.o_ready[0] !== (sb_size(0, 0) != DEPTH))
        $display("FAIL wrap step %0d: got count=%0d ready=%b expected count=%0d", i, cnt(0, 0), bus_a.o_ready[0], sb_size(0, 0));
      else n_pass++;
    end
    while (sb_size(0, 0) != 0 || sb_size(0, 1) != 0) cyc(0, 1'b0, 2'b00, '0, 2'b11);
    n_chk++;
    if (bus_a.o_empty !== 2'b11) $display("FAIL wrap_drain_empty: got %b expected 11", bus_a.o_empty);
    else n_pass++;
  endtask

  task automatic test_credit();
    int pulses = 0;
    repeat (4) cyc(1, 1'b0, 2'b10, next_flit(), 2'b00);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1'b0, 2'b00, '0, 2'b10);
      pulses += int'(bus_b.o_credit_return[1]);
      idle(1);
      pulses += int'(bus_b.o_credit_return[1]);
    end
    n_chk++;
    if (pulses !== 4) $display("FAIL credit_pulses: got %0d expected 4", pulses);
    else n_pass++;
  endtask

  task automatic test_overflow();
    repeat (DEPTH) cyc(1, 1'b0, 2'b01, next_flit(), 2'b00);
    cyc(1, 1'b0, 2'b01, next_flit(), 2'b00);
    n_chk++;
    if (bus_b.o_error !== 2'b01 || cnt(1, 0) !== CW'(DEPTH))
      $display("FAIL overflow: got err=%b count=%0d expected err=01 count=8", bus_b.o_error, cnt(1, 0));
    else n_pass++;
    cyc(1, 1'b0, 2'b01, next_flit(), 2'b01);
    n_chk++;
    if (cnt(1, 0) !== CW'(DEPTH)) $display("FAIL full_push_pop_credit: got count=%0d expected 8", cnt(1, 0));
    else n_pass++;
  endtask

  task automatic test_multi_hot_clear();
    cyc(1, 1'b1, 2'b00, '0, 2'b00);
    cyc(1, 1'b0, 2'b01, next_flit(), 2'b00);
    cyc(1, 1'b0, 2'b11, next_flit(), 2'b00);
    n_chk++;
    if (bus_b.o_error !== 2'b10 || cnt(1, 0) !== CW'(1) || cnt(1, 1) !== '0)
      $display("FAIL multi_hot: got err=%b counts=%0d/%0d expected err=10 counts=1/0", bus_b.o_error, cnt(1, 0), cnt(1, 1));
    else n_pass++;
    cyc(1, 1'b1, 2'b01, next_flit(), 2'b01);
    n_chk++;
    if (bus_b.o_error !== 2'b00 || bus_b.o_count !== '0 || bus_b.o_empty !== 2'b11)
      $display("FAIL clear: got err=%b count=%h empty=%b expected 00/0/11", bus_b.o_error, bus_b.o_count, bus_b.o_empty);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    repeat (5) cyc(0, 1'b0, 2'b01, next_flit(), 2'b00);
    n_chk++;
    if (cnt(0, 0) !== CW'(5)) $display("FAIL pre_reset_count: got %0d expected 5", cnt(0, 0));
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (cnt(0, 0) !== '0 || bus_a.o_empty !== 2'b11 || bus_a.o_valid !== 2'b00)
      $display("FAIL async_reset: got count=%0d empty=%b valid=%b expected 0/11/00", cnt(0, 0), bus_a.o_empty, bus_a.o_valid);
    else n_pass++;
    sb.delete();
    exp_err[0] = 2'b00;
    exp_err[1] = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1'b0, 2'b01, next_flit(), 2'b00);
    cyc(0, 1'b0, 2'b01, next_flit(), 2'b00);
    n_chk++;
    if (cnt(0, 0) !== CW'(2)) $display("FAIL post_reset_count: got %0d expected 2", cnt(0, 0));
    else n_pass++;
    cyc(0, 1'b0, 2'b00, '0, 2'b01);
    cyc(0, 1'b0, 2'b00, '0, 2'b01);
    n_chk++;
    if (bus_a.o_empty[0] !== 1'b1) $display("FAIL post_reset_empty: got %b expected 1", bus_a.o_empty[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_fill();
    test_full_push_pop();
    test_credit();
    test_overflow();
    test_multi_hot_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
